regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Shares the single register-file write port (WE3/A3/WD3) between two writeback requesters: port A (ALU result path) and port B (load/memory path). A two-way round-robin arbiter accepts at most one write per cycle and drives the register file from registered outputs. A 32-entry pending-write scoreboard supplies operand-hazard flags to the decode/issue stage. It sits between the execute/memory stages and the register file.

## Interface
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, register address width; the scoreboard has 2**ADDR_WIDTH entries
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- aValid  input  1  port A write request
- aAddress  input  ADDR_WIDTH  port A destination register
- aData  input  DATA_WIDTH  port A write data
- aReady  output  1  port A accepted this cycle (combinational)
- bValid, bAddress, bData, bReady  same as port A, for port B
- issueValid  input  1  issue stage reserves a destination register
- issueAddress  input  ADDR_WIDTH  reserved destination register
- checkAddress1, checkAddress2  input  ADDR_WIDTH  source operands under decode
- hazard1, hazard2  output  1  operand not yet written back (combinational)
- busy  output  2**ADDR_WIDTH  scoreboard bit vector
- writeEnable  output  1  to register-file WE3 (registered)
- writeAddress  output  ADDR_WIDTH  to A3 (registered)
- writeData  output  DATA_WIDTH  to WD3 (registered)

## Operation
- Arbitration: a one-bit lastGrant records the most recently granted port.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the port that is not lastGrant.
  - lastGrant updates only on a grant.
  - aReady = grant A; bReady = grant B. Both are never high together.
- Acceptance: a request is accepted when valid && ready. Requesters hold valid, address and data stable until accepted.
- Accepted write with address != 0: next cycle writeEnable=1, writeAddress and writeData carry the accepted values.
- Accepted write with address 0: consumed (ready=1), but writeEnable=0 next cycle. x0 is never written.
- No grant: writeEnable=0 next cycle. writeAddress and writeData hold their previous values.
- Scoreboard busy:
  - Set on issueValid when issueAddress != 0.
  - Cleared at the edge where a write to that address is accepted.
  - Set and clear of the same address at the same edge: set wins (a newer reservation).
  - busy[0] is constant 0.
- Hazards: hazardN = busy[checkAddressN] || (writeEnable && writeAddress == checkAddressN && checkAddressN != 0). This covers the cycle in which the write is still in flight to the register file.

## Timing
- Reset values: writeEnable=0, writeAddress=0, writeData=0, busy=all 0, lastGrant=B (so A wins the first contention). aReady and bReady follow valid in the reset cycle, but the edge captures no acceptance while rst=1.
- Latency: request accepted at edge N; writeEnable is asserted during cycle N..N+1; the register file commits at edge N+1.
- Throughput: one write per cycle, sustained. With both ports continuously valid, grants alternate A,B,A,B.
- Reset mid-operation: pending grant and output are discarded; busy clears; requesters must re-present their requests.
- ready, hazard1 and hazard2 are combinational from current inputs and state; all other outputs are registered.

## Structure
- Package regfile_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - NUM_REGS = 2**ADDR_WIDTH
  - port enum PORT_A=0, PORT_B=1 (used for lastGrant)
- Sub-module rr_arbiter2: two-way round-robin arbiter with lastGrant state; inputs two request bits, outputs a one-hot grant.
- The top level holds the output register, scoreboard and hazard logic.

## Test plan
- Single A write: aValid=1, aAddress=5, aData=32'hDEADBEEF for one cycle -> aReady=1 that cycle; next cycle writeEnable=1, writeAddress=5, writeData=32'hDEADBEEF; the following cycle writeEnable=0.
- Contention after reset: A(addr 3) and B(addr 4) both valid for 4 cycles, requests re-presented each cycle -> grants A,B,A,B; output addresses 3,4,3,4 on consecutive cycles.
- x0 write: bValid=1, bAddress=0, bData=32'h12345678 -> bReady=1, writeEnable stays 0; busy[0] stays 0.
- Scoreboard:
  - issueValid with issueAddress=7 -> busy[7]=1; checkAddress1=7 gives hazard1=1.
  - Accept A write to register 7 -> busy[7]=0 at the next edge, hazard1 stays 1 while writeEnable targets register 7, then drops to 0.
- Simultaneous set/clear: issue to register 9 at the same edge an A write to register 9 is accepted -> busy[9]=1 afterwards.
- Reset mid-stream: assert rst while A and B are contending and busy=32'h0000_0F00 -> next cycle writeEnable=0, busy=0; first contention after release grants A.

Source files
------------

// File: rtl/regfile_pkg.sv
// Purpose : shared widths and port encoding for the register-file write arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  // Identifies a writeback requester; also the encoding of lastGrant.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage : regfile_pkg

// File: rtl/regfile_write_arbiter_if.sv
// Purpose : one writeback requester's valid/ready write channel.
// Latency : n/a (wires only).
// Backpressure: requester holds valid/address/data until ready is seen high.
// Signals : valid, address, data from the requester; ready back from the arbiter.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
);

  logic          valid;
  logic [AW-1:0] address;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, output address, output data, input ready);
  modport slave  (input valid, input address, input data, output ready);

endinterface : regfile_write_arbiter_if

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Purpose : two-way round-robin arbiter with a one-bit last-grant memory.
// Latency : grant is combinational from req and state; state updates on the edge.
// Backpressure: a requester not granted simply sees no grant and must retry.
// Ports   : clk, rst, req[1:0] (bit 0 = port A), gnt[1:0] one-hot.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e last_grant_q, last_grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Starting at B lets A win the first contention after reset.
      last_grant_q <= PORT_B;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant_q == PORT_A) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[0]) begin
      last_grant_d = PORT_A;
    end else if (gnt[1]) begin
      last_grant_d = PORT_B;
    end
  end

endmodule : rr_arbiter2

// File: rtl/regfile_write_arbiter.sv
// Purpose : shares the register-file write port between ALU (A) and load (B)
//           writeback, and tracks pending destination registers for decode.
// Latency : accepted write appears on writeEnable/Address/Data one cycle later.
// Backpressure: one acceptance per cycle; losing port sees ready=0 and holds.
// Ports   : aPort/bPort request channels, issue/check scoreboard ports,
//           hazard flags, busy vector, registered register-file write port.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
)(
  input  logic                       clk,
  input  logic                       rst,
  regfile_write_arbiter_if.slave     aPort,
  regfile_write_arbiter_if.slave     bPort,
  input  logic                       issueValid,
  input  logic [ADDR_WIDTH-1:0]      issueAddress,
  input  logic [ADDR_WIDTH-1:0]      checkAddress1,
  input  logic [ADDR_WIDTH-1:0]      checkAddress2,
  output logic                       hazard1,
  output logic                       hazard2,
  output logic [2**ADDR_WIDTH-1:0]   busy,
  output logic                       writeEnable,
  output logic [ADDR_WIDTH-1:0]      writeAddress,
  output logic [DATA_WIDTH-1:0]      writeData
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [1:0]            gnt;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [NREG-1:0]       busy_q, busy_d;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bPort.valid, aPort.valid}),
    .gnt (gnt)
  );

  assign aPort.ready = gnt[0];
  assign bPort.ready = gnt[1];

  assign accept   = |gnt;
  assign acc_addr = gnt[1] ? bPort.address : aPort.address;
  assign acc_data = gnt[1] ? bPort.data    : aPort.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    we_d = accept && (acc_addr != '0);
    wa_d = wa_q;
    wd_d = wd_q;
    // x0 writes are consumed without disturbing the held address/data.
    if (we_d) begin
      wa_d = acc_addr;
      wd_d = acc_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (accept) begin
      busy_d[acc_addr] = 1'b0;
    end
    // Applied after the clear: a same-edge reservation is newer and wins.
    if (issueValid) begin
      busy_d[issueAddress] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy clears at acceptance, but the value only reaches the register file
  // one edge later, so the in-flight write still counts as a hazard.
  assign hazard1 = busy_q[checkAddress1] ||
                   (we_q && (wa_q == checkAddress1) && (checkAddress1 != '0));
  assign hazard2 = busy_q[checkAddress2] ||
                   (we_q && (wa_q == checkAddress2) && (checkAddress2 != '0));

  assign busy         = busy_q;
  assign writeEnable  = we_q;
  assign writeAddress = wa_q;
  assign writeData    = wd_q;

endmodule : regfile_write_arbiter
